// File: rtl/fxp_mult_pipe.sv
// Signed fixed-point multiplier, three-stage valid/ready pipeline.
// Returns the exact product and a rounded, saturated rescale to the operand Q-format.
module fxp_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y_full,
  output logic [WIDTH-1:0]     y_q,
  output logic                 sat
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW:0] ROUND_K = (PW+1)'(1) << (FRAC - 1);
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic [PW-1:0] prod2_q, prod2_d;
  logic [PW-1:0] yFull_q;
  logic [WIDTH-1:0] yQ_q, yQ_d;
  logic sat_q, sat_d;

  logic [PW-1:0] a1Ext, b1Ext;
  logic [PW:0] prodRnd;
  logic signed [PW:0] rShift;
  logic [PW-WIDTH+1:0] rHigh;

  // Each stage advances when it is empty or the stage after it advances,
  // so bubbles are squeezed out even while the consumer stalls.
  assign en3 = !v3_q | out_ready;
  assign en2 = !v2_q | en3;
  assign en1 = !v1_q | en2;
  assign in_ready = en1;

  assign out_valid = v3_q;
  assign y_full    = yFull_q;
  assign y_q       = yQ_q;
  assign sat       = sat_q;

  // Sign-extending before a same-width multiply keeps the low 2*WIDTH bits exact,
  // including the most-negative squared corner.
  always_comb begin
    a1Ext   = {{WIDTH{a1_q[WIDTH-1]}}, a1_q};
    b1Ext   = {{WIDTH{b1_q[WIDTH-1]}}, b1_q};
    prod2_d = a1Ext * b1Ext;
  end

  // One guard bit above the product absorbs the rounding increment; the result
  // fits y_q only when every bit from WIDTH-1 upward equals the sign.
  always_comb begin
    prodRnd = {prod2_q[PW-1], prod2_q} + ROUND_K;
    rShift  = $signed(prodRnd) >>> FRAC;
    rHigh   = rShift[PW:WIDTH-1];
    yQ_d    = rShift[WIDTH-1:0];
    sat_d   = 1'b0;
    if (!((&rHigh) || !(|rHigh))) begin
      sat_d = 1'b1;
      yQ_d  = rShift[PW] ? Q_MIN : Q_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      prod2_q <= '0;
      yFull_q <= '0;
      yQ_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (en1) begin
        v1_q <= in_valid & en1;
        a1_q <= a_in;
        b1_q <= b_in;
      end
      if (en2) begin
        v2_q    <= v1_q;
        prod2_q <= prod2_d;
      end
      if (en3) begin
        v3_q    <= v2_q;
        yFull_q <= prod2_q;
        yQ_q    <= yQ_d;
        sat_q   <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Randomised and directed bench for fxp_mult_pipe, scored against an
// arithmetic reference model and an in-flight queue of expected results.
module tb_fxp_mult_pipe;

  localparam int W = 16;
  localparam int F = 11;

  typedef struct {
    logic [2*W-1:0] full;
    logic [W-1:0]   yq;
    logic           sat;
  } expT;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic inValid = 1'b0;
  logic inReady;
  logic [W-1:0] aIn = '0;
  logic [W-1:0] bIn = '0;
  logic outValid;
  logic outReady = 1'b1;
  logic [2*W-1:0] yFull;
  logic [W-1:0] yQ;
  logic sat;

  int checkCount = 0;
  int errorCount = 0;
  int curRun = 0;
  int maxRun = 0;
  expT expQ[$];

  fxp_mult_pipe #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .reset(resetN),
    .in_valid(inValid), .in_ready(inReady),
    .a_in(aIn), .b_in(bIn),
    .out_valid(outValid), .out_ready(outReady),
    .y_full(yFull), .y_q(yQ), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Real-number semantics: product, add half an LSB, floor-divide, clamp.
  function automatic expT refModel(input logic [W-1:0] a, input logic [W-1:0] b);
    expT e;
    longint p, r, maxV, minV;
    p    = longint'($signed(a)) * longint'($signed(b));
    r    = (p + (longint'(1) << (F - 1))) >>> F;
    maxV = (longint'(1) << (W - 1)) - 1;
    minV = -(longint'(1) << (W - 1));
    e.full = p[2*W-1:0];
    e.sat  = (r > maxV) || (r < minV);
    if (r > maxV) r = maxV;
    if (r < minV) r = minV;
    e.yq = r[W-1:0];
    return e;
  endfunction

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: transfers are decided by the values settled mid-cycle.
  always @(negedge clk) begin
    expT e;
    if (resetN) begin
      checkOutput("in_ready", 64'(inReady), (expQ.size() == 3 && !outReady) ? 64'd0 : 64'd1);
      if (outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 64'(outValid), 64'd0);
        end else begin
          e = expQ[0];
          checkOutput("y_full", 64'(yFull), 64'(e.full));
          checkOutput("y_q", 64'(yQ), 64'(e.yq));
          checkOutput("sat", 64'(sat), 64'(e.sat));
          if (outReady) void'(expQ.pop_front());
        end
      end
      if (outValid && outReady) curRun++;
      else curRun = 0;
      if (curRun > maxRun) maxRun = curRun;
      if (inValid && inReady) expQ.push_back(refModel(aIn, bIn));
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    logic acc;
    inValid = 1'b1;
    aIn = a;
    bIn = b;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idleCycles(input int n);
    inValid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drainPipe();
    int t;
    inValid = 1'b0;
    outReady = 1'b1;
    t = 0;
    while ((expQ.size() != 0 || outValid) && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Counts clock edges from the accepting edge until out_valid is seen.
  task automatic checkBeat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] full, input logic [W-1:0] yqExp, input logic satExp);
    int waited, lat;
    outReady = 1'b1;
    applyStimulus(a, b, waited);
    inValid = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (outValid || lat >= 10) break;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
    checkOutput({tag, "_full"}, 64'(yFull), 64'(full));
    checkOutput({tag, "_yq"}, 64'(yQ), 64'(yqExp));
    checkOutput({tag, "_sat"}, 64'(sat), 64'(satExp));
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] tabA[8] = '{16'h0800, 16'hF800, 16'h0001, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000, 16'h8000};
  logic [W-1:0] tabB[8] = '{16'h0800, 16'h0C00, 16'h0400, 16'h0400, 16'h03FF, 16'h7FFF, 16'h8000, 16'h7FFF};
  logic [2*W-1:0] tabFull[8] = '{32'h00400000, 32'hFFA00000, 32'h00000400, 32'hFFFFFC00,
                                 32'h000003FF, 32'h3FFF0001, 32'h40000000, 32'hC0008000};
  logic [W-1:0] tabYq[8] = '{16'h0800, 16'hF400, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000};
  logic tabSat[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int waited, accepted, idx;
    logic acc;
    logic [W-1:0] bpA[5], bpB[5];
    logic [2*W-1:0] heldFull;
    logic [W-1:0] heldYq;
    logic heldSat;

    #12;
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_y_full", 64'(yFull), 64'd0);
    checkOutput("reset_y_q", 64'(yQ), 64'd0);
    checkOutput("reset_sat", 64'(sat), 64'd0);
    @(posedge clk);
    #3;
    resetN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) checkBeat($sformatf("plan%0d", i), tabA[i], tabB[i], tabFull[i], tabYq[i], tabSat[i]);

    // Back-to-back burst: every beat accepted in one cycle, results with no gaps.
    maxRun = 0;
    curRun = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tabA[i], tabB[i], waited);
      checkOutput("burst_accept", 64'(waited), 64'd1);
    end
    drainPipe();
    checkOutput("burst_no_gap", 64'(maxRun), 64'd8);

    // Backpressure: five beats offered against a stalled consumer.
    for (int i = 0; i < 5; i++) begin
      bpA[i] = randOperand();
      bpB[i] = randOperand();
    end
    outReady = 1'b0;
    inValid = 1'b1;
    accepted = 0;
    aIn = bpA[0];
    bIn = bpB[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        aIn = bpA[accepted];
        bIn = bpB[accepted];
      end
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd3);
    checkOutput("bp_in_ready_low", 64'(inReady), 64'd0);
    checkOutput("bp_out_valid", 64'(outValid), 64'd1);
    heldFull = yFull;
    heldYq = yQ;
    heldSat = sat;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_hold_full", 64'(yFull), 64'(heldFull));
    checkOutput("bp_hold_yq", 64'(yQ), 64'(heldYq));
    checkOutput("bp_hold_sat", 64'(sat), 64'(heldSat));
    outReady = 1'b1;
    #1;
    checkOutput("bp_in_ready_release", 64'(inReady), 64'd1);
    applyStimulus(bpA[3], bpB[3], waited);
    applyStimulus(bpA[4], bpB[4], waited);
    drainPipe();

    // Bubble collapse: X parks at the output, Y and Z still get in.
    outReady = 1'b1;
    applyStimulus(16'h0C00, 16'h0A00, waited);
    idleCycles(2);
    outReady = 1'b0;
    checkOutput("bubble_x_at_output", 64'(outValid), 64'd1);
    applyStimulus(16'hF400, 16'h0300, waited);
    checkOutput("bubble_y_accept", 64'(waited), 64'd1);
    applyStimulus(16'h1234, 16'hE001, waited);
    checkOutput("bubble_z_accept", 64'(waited), 64'd1);
    inValid = 1'b0;
    checkOutput("bubble_x_still_waiting", 64'(outValid), 64'd1);
    drainPipe();

    // Reset mid-stream with three beats in flight.
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(randOperand(), randOperand(), waited);
    inValid = 1'b0;
    #2;
    resetN = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_y_full", 64'(yFull), 64'd0);
    checkOutput("midrst_y_q", 64'(yQ), 64'd0);
    checkOutput("midrst_sat", 64'(sat), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    resetN = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_no_stale", 64'(outValid), 64'd0);
    end
    @(posedge clk);
    #1;
    checkBeat("post_rst", 16'hF800, 16'hF800, 32'h00400000, 16'h0800, 1'b0);

    // Random traffic on both sides, scored by the queue model.
    idx = 0;
    repeat (400) begin
      inValid = ($urandom_range(0, 3) != 0);
      aIn = randOperand();
      bIn = randOperand();
      outReady = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      idx++;
    end
    drainPipe();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
